regfile_mp: RTL and testbench

//  Parametrised multi-port general-purpose register file for the decode/writeback stages.

---
 rtl/regfile_mp_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_mp_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared widths, signal levels and init-FSM state encoding
// for the multi-port register file slice.
package regfile_mp_pkg;

  localparam int   REG_BUS_W    = 32;    // register width
  localparam int   REG_ADDR_W   = 5;     // register address width
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic RESET_ENABLE = 1'b1;

  typedef enum logic {
    ST_INIT = 1'b0,  // zero-fill sweep in progress
    ST_RUN  = 1'b1   // normal operation
  } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard bus of the register file.
//   re/raddr/rdata/rbusy : NUM_RD read ports, packed per port
//   we/waddr/wdata       : NUM_WR write ports, packed per port
//   sb_set/sb_addr       : mark a destination register busy
//   init_done            : zero-fill sweep complete
// master = decode/writeback side, slave = register file.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     init_done;

  modport master (
    output re, raddr, we, waddr, wdata, sb_set, sb_addr,
    input  rdata, rbusy, init_done
  );

  modport slave (
    input  re, raddr, we, waddr, wdata, sb_set, sb_addr,
    output rdata, rbusy, init_done
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: per-register busy bits for decode stall detection.
//   clk, rst : clock, synchronous active-high reset (clears all busy bits)
//   en       : scoreboard updates allowed (file in RUN)
//   we/waddr : write ports; a write clears busy of its target
//   sb_set/sb_addr : issue of a producer; sets busy (wins over a same-cycle clear)
//   rd_ok    : per read port, read is live (not forced to zero)
//   raddr    : read addresses, packed
//   hit      : per read port, read is served by the write bypass
//   rbusy    : per read port, pending write not covered by the bypass
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_RD-1:0]        rd_ok,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_RD-1:0]        hit,
  output logic [NUM_RD-1:0]        rbusy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic             set_ok;

  assign set_ok = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

  // Clears are scheduled before the set so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      busy <= '0;
    end else if (en) begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (we[j] == WRITE_ENABLE) busy[waddr[j*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (set_ok) busy[sb_addr] <= 1'b1;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rbusy[i] = rd_ok[i] & busy[raddr[i*ADDR_W +: ADDR_W]] & ~hit[i];
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file with write-to-read
// bypass, busy scoreboard and a post-reset zero-fill sweep.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_mp_if slave (read ports, write ports, sb_set, init_done)
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              run;
  logic [DATA_W-1:0] regs [DEPTH];

  logic [ADDR_W-1:0] raddr_a [NUM_RD];
  logic [DATA_W-1:0] rdata_a [NUM_RD];
  logic [ADDR_W-1:0] waddr_a [NUM_WR];
  logic [DATA_W-1:0] wdata_a [NUM_WR];
  logic [NUM_RD-1:0] rd_ok, hit;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign raddr_a[i] = bus.raddr[i*ADDR_W +: ADDR_W];
    assign bus.rdata[i*DATA_W +: DATA_W] = rdata_a[i];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign waddr_a[j] = bus.waddr[j*ADDR_W +: ADDR_W];
    assign wdata_a[j] = bus.wdata[j*DATA_W +: DATA_W];
  end

  // Init FSM
  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + {{ADDR_W{1'b0}}, 1'b1};
        if (cnt == LAST) state_nxt = ST_RUN;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign run           = (state == ST_RUN) && (rst != RESET_ENABLE);
  assign bus.init_done = run;

  // Storage: sweep writes zeros; in RUN later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (rst != RESET_ENABLE) begin
      if (state == ST_INIT) begin
        regs[cnt[ADDR_W-1:0]] <= '0;
      end else begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if ((bus.we[j] == WRITE_ENABLE) && !((ZERO_REG != 0) && (waddr_a[j] == '0)))
            regs[waddr_a[j]] <= wdata_a[j];
        end
      end
    end
  end

  // Read muxes: storage, overridden by the highest matching write port.
  always_comb begin
    rd_ok = '0;
    hit   = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rdata_a[i] = '0;
      rd_ok[i]   = run && (bus.re[i] != READ_DISABLE) &&
                   !((ZERO_REG != 0) && (raddr_a[i] == '0));
      if (rd_ok[i]) begin
        rdata_a[i] = regs[raddr_a[i]];
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if ((bus.we[j] == WRITE_ENABLE) && (waddr_a[j] == raddr_a[i])) begin
            rdata_a[i] = wdata_a[j];
            hit[i]     = 1'b1;
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .we     (bus.we),
    .waddr  (bus.waddr),
    .sb_set (bus.sb_set),
    .sb_addr(bus.sb_addr),
    .rd_ok  (rd_ok),
    .raddr  (bus.raddr),
    .hit    (hit),
    .rbusy  (bus.rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp (32x32, 2R/2W).
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) rf ();

  regfile_mp #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_RD  (2),
    .NUM_WR  (2),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(rf)
  );

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        sb;
    logic [4:0]  sa;
    logic [31:0] e0, e1;
    logic [1:0]  eb;   // {rbusy1, rbusy0}
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic sb, input logic [4:0] sa,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    vec_t v;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa0 = wa0; v.wd0 = wd0;
    v.wa1 = wa1; v.wd1 = wd1; v.sb = sb; v.sa = sa; v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    rf.re = '0; rf.raddr = '0; rf.we = '0; rf.waddr = '0; rf.wdata = '0;
    rf.sb_set = 1'b0; rf.sb_addr = '0;
  endtask

  task automatic apply(input vec_t v);
    rf.re = v.re; rf.raddr = {v.ra1, v.ra0};
    rf.we = v.we; rf.waddr = {v.wa1, v.wa0}; rf.wdata = {v.wd1, v.wd0};
    rf.sb_set = v.sb; rf.sb_addr = v.sa;
  endtask

  // Counts rising edges after rst release; init_done must rise exactly after edge 32.
  // With junk set, writes/sb_set to r7 and reads of r7 are driven during the sweep.
  task automatic sweep(input string tag, input bit junk);
    if (junk) begin
      rf.re = 2'b11; rf.raddr = {5'd7, 5'd7};
      rf.we = 2'b01; rf.waddr = {5'd0, 5'd7}; rf.wdata = {32'h0, 32'hDEAD_BEEF};
      rf.sb_set = 1'b1; rf.sb_addr = 5'd7;
    end
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s init_done c%0d", tag, k), {31'b0, rf.init_done}, (k >= 32) ? 32'd1 : 32'd0);
      if (junk && k < 32) begin
        check($sformatf("%s rdata0 c%0d", tag, k), rf.rdata[31:0], 32'h0);
        check($sformatf("%s rbusy c%0d", tag, k), {30'b0, rf.rbusy}, 32'h0);
      end
      if (k == 31) idle();
    end
  endtask

  initial begin
    //           re     ra0    ra1    we     wa0    wd0           wa1    wd1           sb    sa     e0            e1            eb
    vt[0]  = mk(2'b11, 5'd5,  5'd5,  2'b11, 5'd5,  32'h1111,     5'd5,  32'h2222,     1'b0, 5'd0,  32'h2222,     32'h2222,     2'b00);
    vt[1]  = mk(2'b11, 5'd5,  5'd7,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h2222,     32'h0,        2'b00);
    vt[2]  = mk(2'b11, 5'd0,  5'd3,  2'b11, 5'd3,  32'hABCD,     5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,        32'hABCD,     2'b00);
    vt[3]  = mk(2'b10, 5'd3,  5'd3,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'hABCD,     2'b00);
    vt[4]  = mk(2'b11, 5'd9,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  32'h0,        32'h0,        2'b00);
    vt[5]  = mk(2'b01, 5'd9,  5'd9,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b01);
    vt[6]  = mk(2'b11, 5'd9,  5'd9,  2'b01, 5'd9,  32'h55,       5'd0,  32'h0,        1'b0, 5'd0,  32'h55,       32'h55,       2'b00);
    vt[7]  = mk(2'b11, 5'd9,  5'd9,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h55,       32'h55,       2'b00);
    vt[8]  = mk(2'b01, 5'd4,  5'd0,  2'b01, 5'd4,  32'h44,       5'd0,  32'h0,        1'b1, 5'd4,  32'h44,       32'h0,        2'b00);
    vt[9]  = mk(2'b11, 5'd4,  5'd4,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h44,       32'h44,       2'b11);
    vt[10] = mk(2'b01, 5'd0,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0,  32'h0,        32'h0,        2'b00);
    vt[11] = mk(2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        2'b00);
    vt[12] = mk(2'b11, 5'd6,  5'd8,  2'b11, 5'd6,  32'hAAAA,     5'd8,  32'hBBBB,     1'b0, 5'd0,  32'hAAAA,     32'hBBBB,     2'b00);
    vt[13] = mk(2'b11, 5'd6,  5'd8,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'hAAAA,     32'hBBBB,     2'b00);
    vt[14] = mk(2'b11, 5'd4,  5'd10, 2'b10, 5'd0,  32'h0,        5'd4,  32'h99,       1'b1, 5'd10, 32'h99,       32'h0,        2'b00);
    vt[15] = mk(2'b11, 5'd4,  5'd10, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  32'h99,       32'h0,        2'b10);
    vt[16] = mk(2'b11, 5'd5,  5'd6,  2'b11, 5'd5,  32'h3333,     5'd6,  32'hCCCC,     1'b0, 5'd0,  32'h3333,     32'hCCCC,     2'b00);

    idle();
    // Reset: outputs quiet even with reads/writes driven.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rf.re = 2'b11; rf.raddr = {5'd7, 5'd7}; rf.we = 2'b01; rf.waddr = {5'd0, 5'd7};
    rf.wdata = {32'h0, 32'h1234_5678};
    #1;
    check("rst init_done", {31'b0, rf.init_done}, 32'h0);
    check("rst rdata0", rf.rdata[31:0], 32'h0);
    check("rst rbusy", {30'b0, rf.rbusy}, 32'h0);
    rst = 1'b0;
    sweep("first", 1'b1);

    // Writes/sb_set to r7 during the sweep must have been dropped.
    rf.re = 2'b01; rf.raddr = {5'd0, 5'd7};
    #1;
    check("r7 after sweep rdata", rf.rdata[31:0], 32'h0);
    check("r7 after sweep rbusy", {30'b0, rf.rbusy}, 32'h0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      apply(vt[i]);
      #1;
      check($sformatf("v%0d rdata0", i), rf.rdata[31:0], vt[i].e0);
      check($sformatf("v%0d rdata1", i), rf.rdata[63:32], vt[i].e1);
      check($sformatf("v%0d rbusy", i), {30'b0, rf.rbusy}, {30'b0, vt[i].eb});
      @(posedge clk);
      @(negedge clk);
    end
    idle();

    // Reset in RUN: reads forced quiet while rst is high (r4=0x99, r10 busy).
    rst = 1'b1;
    rf.re = 2'b11; rf.raddr = {5'd10, 5'd4};
    #1;
    check("run rst init_done", {31'b0, rf.init_done}, 32'h0);
    check("run rst rdata0", rf.rdata[31:0], 32'h0);
    check("run rst rbusy", {30'b0, rf.rbusy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Abort the sweep after 10 cycles, then require a full 32-cycle sweep.
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 10) check("mid sweep init_done", {31'b0, rf.init_done}, 32'h0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sweep("second", 1'b0);

    rf.re = 2'b11; rf.raddr = {5'd10, 5'd4};
    #1;
    check("post sweep r4", rf.rdata[31:0], 32'h0);
    check("post sweep r10 rdata", rf.rdata[63:32], 32'h0);
    check("post sweep rbusy", {30'b0, rf.rbusy}, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
